// File: rtl/fb_write_arbiter.sv
// Frame buffer write-port arbiter: single brush pixel writes in idle, or a full-frame
// clear sweep (one write per cycle) followed by a one-cycle done pulse.
module fb_write_arbiter #(
   parameter int unsigned H_PIXELS    = 640,
   parameter int unsigned V_PIXELS    = 360,
   parameter int unsigned COLOR_WIDTH = 4
) (
   input  logic                   pixel_clk_in,
   input  logic                   rst_in,
   input  logic                   clear_in,
   input  logic [COLOR_WIDTH-1:0] clear_color_in,
   input  logic                   brush_valid_in,
   input  logic [9:0]             brush_x_in,
   input  logic [8:0]             brush_y_in,
   input  logic [COLOR_WIDTH-1:0] brush_color_in,
   output logic                   brush_ready_out,
   output logic                   wr_en_out,
   output logic [17:0]            wr_addr_out,
   output logic [COLOR_WIDTH-1:0] wr_data_out,
   output logic                   busy_out,
   output logic                   clear_done_out
);

   localparam logic [17:0] HWidth   = 18'(H_PIXELS);
   localparam logic [17:0] LastAddr = 18'(H_PIXELS * V_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   state_t                 state;
   logic [17:0]            count;
   logic [COLOR_WIDTH-1:0] color;

   logic [17:0] x_ext;
   logic [17:0] y_ext;
   logic [17:0] brush_addr;
   logic        brush_in_range;
   logic        brush_accept;

   always_comb begin
      x_ext          = {8'd0, brush_x_in};
      y_ext          = {9'd0, brush_y_in};
      brush_addr     = x_ext + HWidth * y_ext;
      brush_in_range = ({22'd0, brush_x_in} < H_PIXELS) && ({23'd0, brush_y_in} < V_PIXELS);
      // Reset also blocks acceptance so nothing is handshaken while held in reset.
      brush_ready_out = (state == IDLE) && !clear_in && !rst_in;
      brush_accept    = brush_valid_in && brush_ready_out;
   end

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         state          <= IDLE;
         count          <= '0;
         color          <= '0;
         wr_en_out      <= 1'b0;
         wr_addr_out    <= '0;
         wr_data_out    <= '0;
         busy_out       <= 1'b0;
         clear_done_out <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               clear_done_out <= 1'b0;
               if (clear_in) begin
                  // Address 0 goes out immediately; count tracks the address on the port.
                  state       <= CLEAR;
                  count       <= '0;
                  color       <= clear_color_in;
                  wr_en_out   <= 1'b1;
                  wr_addr_out <= '0;
                  wr_data_out <= clear_color_in;
                  busy_out    <= 1'b1;
               end else if (brush_accept) begin
                  wr_en_out   <= brush_in_range;
                  wr_addr_out <= brush_addr;
                  wr_data_out <= brush_color_in;
                  busy_out    <= 1'b0;
               end else begin
                  wr_en_out <= 1'b0;
                  busy_out  <= 1'b0;
               end
            end
            CLEAR: begin
               if (count == LastAddr) begin
                  state          <= DONE;
                  wr_en_out      <= 1'b0;
                  busy_out       <= 1'b0;
                  clear_done_out <= 1'b1;
               end else begin
                  count       <= count + 18'd1;
                  wr_en_out   <= 1'b1;
                  wr_addr_out <= count + 18'd1;
                  wr_data_out <= color;
                  busy_out    <= 1'b1;
               end
            end
            DONE: begin
               state          <= IDLE;
               wr_en_out      <= 1'b0;
               busy_out       <= 1'b0;
               clear_done_out <= 1'b0;
            end
            default: begin
               state          <= IDLE;
               wr_en_out      <= 1'b0;
               busy_out       <= 1'b0;
               clear_done_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: per-cycle reference model plus a shadow frame
// buffer compared against the frame rebuilt from observed writes.
module tb_fb_write_arbiter;

   localparam int H     = 640;
   localparam int V     = 4;
   localparam int TOTAL = H * V;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic [3:0]  clear_color = '0;
   logic        valid = 1'b0;
   logic [9:0]  bx = '0;
   logic [8:0]  by = '0;
   logic [3:0]  bc = '0;
   logic        ready;
   logic        wr_en;
   logic [17:0] wr_addr;
   logic [3:0]  wr_data;
   logic        busy;
   logic        done;

   fb_write_arbiter #(.H_PIXELS(H), .V_PIXELS(V), .COLOR_WIDTH(4)) dut (
      .pixel_clk_in   (clk),
      .rst_in         (rst),
      .clear_in       (clear),
      .clear_color_in (clear_color),
      .brush_valid_in (valid),
      .brush_x_in     (bx),
      .brush_y_in     (by),
      .brush_color_in (bc),
      .brush_ready_out(ready),
      .wr_en_out      (wr_en),
      .wr_addr_out    (wr_addr),
      .wr_data_out    (wr_data),
      .busy_out       (busy),
      .clear_done_out (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: m_sweep is the sweep address currently on the port (-1 when not sweeping).
   int       m_sweep = -1;
   bit       m_done  = 1'b0;
   bit       m_known = 1'b0;
   logic [3:0] m_color = '0;
   logic [3:0] ref_fb[TOTAL];
   logic [3:0] dut_fb[TOTAL];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      bit   idle;
      bit   e_en, e_busy, e_done;
      int   e_addr;
      logic [3:0] e_data;
      #1;
      idle = (m_sweep < 0) && !m_done;
      if (m_known) chk("ready", 32'(ready), 32'(idle && !clear && !rst));
      e_en = 0; e_busy = 0; e_done = 0; e_addr = 0; e_data = '0;
      if (rst) begin
         m_sweep = -1; m_done = 0; m_color = '0; m_known = 1;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_sweep >= 0) begin
         if (m_sweep == TOTAL - 1) begin
            m_sweep = -1; m_done = 1; e_done = 1;
         end else begin
            m_sweep++;
            e_en = 1; e_busy = 1; e_addr = m_sweep; e_data = m_color;
         end
      end else if (clear) begin
         m_color = clear_color; m_sweep = 0;
         e_en = 1; e_busy = 1; e_addr = 0; e_data = clear_color;
      end else if (valid && int'(bx) < H && int'(by) < V) begin
         e_en = 1; e_addr = int'(bx) + H * int'(by); e_data = bc;
      end
      @(posedge clk);
      #1;
      chk("wr_en", 32'(wr_en), 32'(e_en));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      if (e_en || rst) begin
         chk("wr_addr", 32'(wr_addr), 32'(e_addr));
         chk("wr_data", 32'(wr_data), 32'(e_data));
      end
      if (e_en) ref_fb[e_addr] = e_data;
      if (wr_en && int'(wr_addr) < TOTAL) dut_fb[int'(wr_addr)] = wr_data;
   endtask

   task automatic idle_inputs();
      clear = 0; valid = 0;
   endtask

   task automatic brush(input int x, input int y, input int c);
      valid = 1; bx = 10'(x); by = 9'(y); bc = 4'(c);
   endtask

   initial begin
      int nbad;
      for (int i = 0; i < TOTAL; i++) begin
         ref_fb[i] = '0;
         dut_fb[i] = '0;
      end
      @(posedge clk);
      #1;
      // Reset
      rst = 1;
      step();
      chk("ready_in_reset", 32'(ready), 32'd0);
      step();
      rst = 0;

      // Directed brush write and out-of-range drop
      brush(10, 2, 3);
      step();
      chk("brush_addr_1290", 32'(wr_addr), 32'd1290);
      brush(640, 0, 5);
      step();
      idle_inputs();
      step();

      // Random brush traffic including edge coordinates
      for (int i = 0; i < 60; i++) begin
         valid = 1'($urandom_range(0, 1));
         bx = 10'($urandom_range(0, 700));
         by = 9'($urandom_range(0, 6));
         bc = 4'($urandom);
         if (i % 10 == 0) bx = 10'(H - 1);
         if (i % 10 == 1) by = 9'(V - 1);
         step();
      end
      idle_inputs();

      // Full clear to color 1
      clear = 1; clear_color = 4'd1;
      step();
      clear = 0;
      for (int i = 0; i < TOTAL + 3; i++) begin
         valid = 1'($urandom_range(0, 1));
         step();
      end
      idle_inputs();

      // Collision: clear wins over brush, then a second clear at address 1000 is ignored
      clear = 1; clear_color = 4'd2;
      brush(5, 1, 7);
      step();
      idle_inputs();
      for (int i = 0; i < 1100 && m_sweep != 1000; i++) step();
      chk("reached_1000", 32'(m_sweep), 32'd1000);
      clear = 1; clear_color = 4'd5;
      step();
      clear = 0;
      for (int i = 0; i < TOTAL; i++) step();

      // Reset mid-sweep
      clear = 1; clear_color = 4'd9;
      step();
      clear = 0;
      for (int i = 0; i < 2100 && m_sweep != 2000; i++) step();
      chk("reached_2000", 32'(m_sweep), 32'd2000);
      rst = 1;
      step();
      rst = 0;
      #1;
      chk("ready_after_reset", 32'(ready), 32'd1);
      step();
      step();

      // Random brush traffic after the partial sweep
      for (int i = 0; i < 60; i++) begin
         valid = 1'($urandom_range(0, 1));
         bx = 10'($urandom_range(0, 660));
         by = 9'($urandom_range(0, 5));
         bc = 4'($urandom);
         step();
      end
      idle_inputs();
      step();

      nbad = 0;
      for (int i = 0; i < TOTAL; i++) if (ref_fb[i] !== dut_fb[i]) nbad++;
      chk("frame_contents", 32'(nbad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, frame width in pixels.
REQ-002 SHALL have parameter V_PIXELS, default 360, frame height in pixels.
REQ-003 SHALL have parameter COLOR_WIDTH, default 4, palette index width.
REQ-004 SHALL have port pixel_clk_in, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in, input, 1, synchronous active-high reset.
REQ-006 SHALL have port clear_in, input, 1, request a full-frame clear.
REQ-007 SHALL have port clear_color_in, input, COLOR_WIDTH, fill color, sampled when clear_in is accepted.
REQ-008 SHALL have port brush_valid_in, input, 1, brush pixel write request.
REQ-009 SHALL have port brush_x_in, input, 10, brush pixel column.
REQ-010 SHALL have port brush_y_in, input, 9, brush pixel row.
REQ-011 SHALL have port brush_color_in, input, COLOR_WIDTH, brush pixel color.
REQ-012 SHALL have port brush_ready_out, output, 1, brush request accepted this cycle if valid.
REQ-013 SHALL have port wr_en_out, output, 1, frame buffer write-port enable.
REQ-014 SHALL have port wr_addr_out, output, 18, frame buffer write address.
REQ-015 SHALL have port wr_data_out, output, COLOR_WIDTH, frame buffer write data.
REQ-016 SHALL have port busy_out, output, 1, clear sweep in progress.
REQ-017 SHALL have port clear_done_out, output, 1, one-cycle pulse at end of sweep.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, DONE.
REQ-019 SHALL drive brush_ready_out combinationally as (state==IDLE) && !clear_in.
REQ-020 SHALL accept a brush request when brush_valid_in && brush_ready_out.
REQ-021 SHALL compute brush address as x + H_PIXELS*y, zero-extended to 18 bits before multiply.
REQ-022 SHALL, for an accepted in-range brush request (x<H_PIXELS, y<V_PIXELS), register wr_en_out=1, wr_addr_out and wr_data_out=brush_color_in, visible the cycle after acceptance (latency 1).
REQ-023 SHALL accept but drop out-of-range brush requests: wr_en_out=0 the following cycle.
REQ-024 SHALL, in IDLE with clear_in=1, latch clear_color_in, zero the sweep counter and enter CLEAR; clear_in wins over a simultaneous brush_valid_in (brush not accepted).
REQ-025 SHALL, in CLEAR, output one write per cycle: wr_en_out=1, wr_addr_out=counter, wr_data_out=latched color, counter incrementing 0..H_PIXELS*V_PIXELS-1 with no gaps.
REQ-026 SHALL first present address 0 the cycle after clear_in is accepted and the last address (230399 default) H_PIXELS*V_PIXELS-1 cycles later.
REQ-027 SHALL enter DONE after the last sweep write, assert clear_done_out=1 and wr_en_out=0 for exactly that one cycle, then return to IDLE.
REQ-028 SHALL hold busy_out=1 in every cycle wr_en_out carries a sweep write, 0 otherwise.
REQ-029 SHALL ignore clear_in while in CLEAR or DONE (no restart, no queueing).
REQ-030 SHALL hold brush_ready_out=0 throughout CLEAR and DONE; brush requests are not buffered.
REQ-031 SHALL drive wr_en_out=0 in IDLE whenever no brush request was accepted the previous cycle.
REQ-032 SHALL never wrap the sweep counter; counter stops at the last address.

Reset
REQ-033 SHALL, on rst_in=1 at a clock edge, enter IDLE and drive wr_en_out=0, wr_addr_out=0, wr_data_out=0, busy_out=0, clear_done_out=0, counter=0, latched color=0.
REQ-034 SHALL abandon an in-progress sweep on reset with no clear_done_out pulse.
REQ-035 SHALL hold brush_ready_out=0 during any cycle rst_in=1.

Verification
REQ-036 Brush write: IDLE, valid, x=10, y=2, color=3 -> next cycle wr_en_out=1, wr_addr_out=1290, wr_data_out=3.
REQ-037 Out of range: valid, x=640, y=0 -> ready=1, next cycle wr_en_out=0.
REQ-038 Full clear: clear_in pulse, color=1 -> 230400 consecutive writes addr 0..230399 data 1, busy_out high throughout, then clear_done_out=1 one cycle, ready=1 following cycle.
REQ-039 Collision: clear_in=1 and brush_valid_in=1 same cycle in IDLE -> ready=0, first write addr 0 with clear color, brush pixel never written.
REQ-040 Clear during sweep: second clear_in at address 1000 -> sweep continues uninterrupted to 230399, single done pulse.
REQ-041 Reset mid-sweep: rst_in at address 5000 -> next cycle wr_en_out=0, busy_out=0, no done pulse, ready=1 after rst_in drops.
